// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style core: opcode constants (decoded by
// the control unit and checked by the program loader), the end-of-program
// marker, and the loader state/status encodings.
package mips_pkg;

  // Primary opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LHU  = 6'b100101;
  localparam logic [5:0] OP_LWU  = 6'b100111;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_SH   = 6'b101001;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // End-of-program marker; it is itself written to instruction memory
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_RECV  = 3'd1,
    LD_WRITE = 3'd2,
    LD_DONE  = 3'd3,
    LD_ERROR = 3'd4
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_OVERFLOW = 2'b10
  } loader_err_t;

  // True for every opcode the control unit decodes
  function automatic logic is_supported_opcode(input logic [5:0] op);
    case (op)
      OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ORI,
      OP_XORI, OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU,
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-in / word-out bus of the program loader.
//   i_rx_data / i_rx_valid : byte stream from the debug UART receiver
//   o_imem_we / o_imem_addr / o_imem_data : instruction memory write port
// master: the loader (consumes bytes, drives the memory port)
// slave : the environment (UART side source, memory side sink)
interface program_loader_if #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_ADDR = 10
) ();
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic               o_imem_we;
  logic [NB_ADDR-1:0] o_imem_addr;
  logic [NB_DATA-1:0] o_imem_data;

  modport master (
    input  i_rx_data, i_rx_valid,
    output o_imem_we, o_imem_addr, o_imem_data
  );

  modport slave (
    output i_rx_data, i_rx_valid,
    input  o_imem_we, o_imem_addr, o_imem_data
  );
endinterface

// File: rtl/program_loader_timeout_counter.sv
// loader_timeout_counter: inter-byte idle down-counter.
//   clk, i_rst : clock, synchronous active-high reset
//   i_clear    : force count to zero
//   i_load     : reload with TIMEOUT-1 (a byte was just taken)
//   i_en       : count one idle cycle
//   o_tc       : terminal count, the TIMEOUT-th idle cycle is in progress
module loader_timeout_counter #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);
  localparam int                NB_CNT   = $clog2(TIMEOUT + 1);
  localparam logic [NB_CNT-1:0] LOAD_VAL = NB_CNT'(TIMEOUT - 1);

  logic [NB_CNT-1:0] cnt;

  always_ff @(posedge clk) begin
    if (i_rst || i_clear)         cnt <= '0;
    else if (i_load)              cnt <= LOAD_VAL;
    else if (i_en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  // Loaded with TIMEOUT-1 on the byte cycle, so zero is reached on the
  // TIMEOUT-th idle cycle after it.
  assign o_tc = i_en && (cnt == '0);
endmodule

// File: rtl/program_loader.sv
// program_loader: packs a UART byte stream MSB-first into instructions and
// writes them to instruction memory from word 0 while holding the CPU.
//   clk, i_rst      : clock, synchronous active-high reset
//   i_start         : one-cycle load command (honoured in IDLE only)
//   bus (master)    : rx byte in, imem write port out
//   o_cpu_hold      : CPU must not fetch
//   o_busy          : loader in RECV or WRITE
//   o_done          : one-cycle pulse after HALT word written
//   o_error         : sticky 00 none / 01 timeout / 10 overflow
//   o_illegal_op    : sticky, an undecodable opcode was written
//   o_illegal_addr  : address of the first such word
//   o_word_count    : words written in this load, HALT included
module program_loader
  import mips_pkg::*;
#(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_BYTE   = 8,
  parameter int                 NB_ADDR   = 10,
  parameter logic [NB_DATA-1:0] HALT_WORD = mips_pkg::HALT_WORD,
  parameter int                 TIMEOUT   = 100000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  program_loader_if.master   bus,
  output logic               o_cpu_hold,
  output logic               o_busy,
  output logic               o_done,
  output logic [1:0]         o_error,
  output logic               o_illegal_op,
  output logic [NB_ADDR-1:0] o_illegal_addr,
  output logic [NB_ADDR:0]   o_word_count
);
  localparam int                 BYTES   = NB_DATA / NB_BYTE;
  localparam int                 NB_BCNT = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [NB_BCNT-1:0] LAST_B  = NB_BCNT'(BYTES - 1);

  loader_state_t      state, state_nxt;
  logic [NB_BCNT-1:0] byte_cnt;
  logic [NB_DATA-1:0] word_buf;
  logic [NB_ADDR-1:0] addr;

  logic byte_take, last_byte, tmo_en, tmo_tc, tmo_clr, start_ok;
  logic is_halt, addr_last, op_bad;

  assign start_ok  = (state == LD_IDLE) && i_start;
  // Bytes are taken in RECV and also in WRITE, so a strobe landing on the
  // write cycle becomes byte 0 of the next word.
  assign byte_take = ((state == LD_RECV) || (state == LD_WRITE)) && bus.i_rx_valid;
  assign last_byte = (state == LD_RECV) && bus.i_rx_valid && (byte_cnt == LAST_B);
  // Only count idle time inside a partially received word
  assign tmo_en    = (state == LD_RECV) && (byte_cnt != '0) && !bus.i_rx_valid;
  assign tmo_clr   = start_ok;
  assign is_halt   = (word_buf == HALT_WORD);
  assign addr_last = &addr;
  assign op_bad    = !is_supported_opcode(word_buf[NB_DATA-1 -: 6]) && !is_halt;

  loader_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_clear (tmo_clr),
    .i_load  (byte_take),
    .i_en    (tmo_en),
    .o_tc    (tmo_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (i_rst) state <= LD_IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE:  if (i_start) state_nxt = LD_RECV;
      LD_RECV: begin
        if (last_byte)   state_nxt = LD_WRITE;
        else if (tmo_tc) state_nxt = LD_ERROR;
      end
      LD_WRITE: begin
        if (is_halt)        state_nxt = LD_DONE;
        else if (addr_last) state_nxt = LD_ERROR;
        else                state_nxt = LD_RECV;
      end
      LD_DONE:  state_nxt = LD_IDLE;
      LD_ERROR: state_nxt = LD_IDLE;
      default:  state_nxt = LD_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.o_imem_we = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    case (state)
      LD_RECV:  o_busy = 1'b1;
      LD_WRITE: begin
        o_busy        = 1'b1;
        bus.o_imem_we = 1'b1;
      end
      LD_DONE:  o_done = 1'b1;
      default:  ;
    endcase
  end

  assign o_cpu_hold      = o_busy;
  assign bus.o_imem_addr = addr;
  assign bus.o_imem_data = word_buf;

  // Datapath and sticky status
  always_ff @(posedge clk) begin
    if (i_rst) begin
      byte_cnt       <= '0;
      word_buf       <= '0;
      addr           <= '0;
      o_word_count   <= '0;
      o_error        <= ERR_NONE;
      o_illegal_op   <= 1'b0;
      o_illegal_addr <= '0;
    end else begin
      if (byte_take) begin
        word_buf <= {word_buf[NB_DATA-NB_BYTE-1:0], bus.i_rx_data};
        byte_cnt <= byte_cnt + 1'b1;
      end
      case (state)
        LD_IDLE: if (i_start) begin
          byte_cnt       <= '0;
          addr           <= '0;
          o_word_count   <= '0;
          o_error        <= ERR_NONE;
          o_illegal_op   <= 1'b0;
          o_illegal_addr <= '0;
        end
        // Partial word is simply abandoned; the next start clears byte_cnt
        LD_RECV: if (!last_byte && tmo_tc) o_error <= ERR_TIMEOUT;
        LD_WRITE: begin
          o_word_count <= o_word_count + 1'b1;
          if (op_bad && !o_illegal_op) begin
            o_illegal_op   <= 1'b1;
            o_illegal_addr <= addr;
          end
          if (!is_halt) begin
            if (addr_last) o_error <= ERR_OVERFLOW;
            else           addr    <= addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  localparam int          NB_DATA = 32;
  localparam int          NB_BYTE = 8;
  localparam int          NB_ADDR = 2;
  localparam int          TIMEOUT = 16;
  localparam int          DEPTH   = 1 << NB_ADDR;
  localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

  logic               clk = 1'b0;
  logic               i_rst, i_start;
  logic               o_cpu_hold, o_busy, o_done, o_illegal_op;
  logic [1:0]         o_error;
  logic [NB_ADDR-1:0] o_illegal_addr;
  logic [NB_ADDR:0]   o_word_count;

  program_loader_if #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NB_ADDR(NB_ADDR)) bus ();

  program_loader #(
    .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NB_ADDR(NB_ADDR),
    .HALT_WORD(HALT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .bus            (bus),
    .o_cpu_hold     (o_cpu_hold),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_illegal_op   (o_illegal_op),
    .o_illegal_addr (o_illegal_addr),
    .o_word_count   (o_word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Decodable opcodes, listed independently of the design package
  logic [5:0] legal_ops [0:18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
                                   6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24,
                                   6'h25, 6'h27, 6'h28, 6'h29, 6'h2B};

  function automatic bit op_ok(input logic [5:0] op);
    for (int i = 0; i < 19; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rnd_word();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return {legal_ops[$urandom_range(0, 18)], 26'($urandom)};
  endfunction

  // Write monitor
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt;

  always @(negedge clk) begin
    if (bus.o_imem_we) begin
      wr_addr_q.push_back(32'(bus.o_imem_addr));
      wr_data_q.push_back(bus.o_imem_data);
    end
    if (o_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    i_start  = 1'b1;
    tick();
    i_start  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_idle_bound"}, 32'(n < 200), 32'd1);
    repeat (3) tick();
  endtask

  // Reference model: words go to 0,1,2.. until HALT (written) or the last
  // address (written, then overflow). Trailing partial bytes mean timeout.
  task automatic run_load(input string tag, input logic [31:0] w[$],
                          input int gap_max, input int partial);
    int       n_exp = 0;
    bit       halt  = 0;
    bit       ill   = 0;
    int       ill_a = 0;
    int       err;
    for (int i = 0; i < w.size(); i++) begin
      if (halt || n_exp == DEPTH) break;
      if (!ill && w[i] != HALT && !op_ok(w[i][31:26])) begin
        ill   = 1;
        ill_a = n_exp;
      end
      n_exp++;
      if (w[i] == HALT) halt = 1;
    end
    if (halt)               err = 0;
    else if (n_exp == DEPTH) err = 2;
    else                    err = 1;

    pulse_start();
    for (int i = 0; i < n_exp; i++)
      for (int b = 0; b < 4; b++)
        send_byte(8'(w[i] >> (24 - 8 * b)), $urandom_range(0, gap_max));
    if (!halt && n_exp < DEPTH)
      for (int p = 0; p < partial; p++)
        send_byte(8'($urandom), $urandom_range(0, gap_max));
    wait_idle(tag);

    chk({tag, "_nwr"}, wr_addr_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
      chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], w[i]);
    end
    chk({tag, "_wcnt"},   32'(o_word_count),   n_exp);
    chk({tag, "_err"},    32'(o_error),        err);
    chk({tag, "_ill"},    32'(o_illegal_op),   32'(ill));
    chk({tag, "_illa"},   32'(o_illegal_addr), ill ? ill_a : 0);
    chk({tag, "_done"},   done_cnt,            32'(halt));
    chk({tag, "_hold"},   32'(o_cpu_hold),     32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wq[$];
    i_rst = 1'b1;
    i_start = 1'b0;
    bus.i_rx_data = '0;
    bus.i_rx_valid = 1'b0;
    done_cnt = 0;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();

    chk("rst_busy", 32'(o_busy),       0);
    chk("rst_hold", 32'(o_cpu_hold),   0);
    chk("rst_we",   32'(bus.o_imem_we), 0);
    chk("rst_err",  32'(o_error),      0);
    chk("rst_wcnt", 32'(o_word_count), 0);
    chk("rst_ill",  32'(o_illegal_op), 0);
    chk("rst_done", 32'(o_done),       0);

    // Bytes in IDLE are ignored
    wr_addr_q.delete();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
    repeat (3) tick();
    chk("idle_nwr",  wr_addr_q.size(), 0);
    chk("idle_busy", 32'(o_busy), 0);

    wq = '{32'h2008_0005, HALT};
    run_load("basic", wq, 2, 0);

    wq = '{32'hFC00_0000, 32'h2008_0005, HALT};
    run_load("illegal", wq, 1, 0);

    wq = '{};
    run_load("timeout", wq, 0, 2);

    wq = '{32'h8C01_0004, 32'hAC01_0008, 32'h1000_FFFF, 32'h3421_00FF, 32'h2008_0001};
    run_load("overflow", wq, 1, 0);

    wq = '{32'h0022_1820, 32'h3C01_ABCD, HALT};
    run_load("b2b", wq, 0, 0);

    // Reset in the middle of a word
    pulse_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 1);
    i_rst = 1'b1;
    tick();
    chk("mrst_busy", 32'(o_busy),          0);
    chk("mrst_hold", 32'(o_cpu_hold),      0);
    chk("mrst_addr", 32'(bus.o_imem_addr), 0);
    chk("mrst_data", bus.o_imem_data,      0);
    chk("mrst_stat", {o_error, o_illegal_op, 32'(o_illegal_addr), 32'(o_word_count)}, 0);
    i_rst = 1'b0;
    tick();
    wq = '{32'h3C01_ABCD, HALT};
    run_load("post_rst", wq, 1, 0);

    for (int it = 0; it < 20; it++) begin
      int kind = $urandom_range(0, 2);
      int gap  = $urandom_range(0, 3);
      wq.delete();
      case (kind)
        0: begin
          int m = $urandom_range(0, 3);
          for (int i = 0; i < m; i++) wq.push_back(rnd_word());
          wq.push_back(HALT);
          run_load($sformatf("rnd%0d_halt", it), wq, gap, 0);
        end
        1: begin
          for (int i = 0; i < DEPTH + 1; i++) wq.push_back(rnd_word());
          run_load($sformatf("rnd%0d_ovf", it), wq, gap, 0);
        end
        default: begin
          int m = $urandom_range(0, DEPTH - 1);
          for (int i = 0; i < m; i++) wq.push_back(rnd_word());
          run_load($sformatf("rnd%0d_tmo", it), wq, gap, $urandom_range(1, 3));
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
